// File: rtl/binary_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// binary_bcd_seq_if
//   Handshake bundle for the sequential binary-to-BCD converter.
//
//   Handshake rules (both sides):
//     - Input side: the producer raises start with data_in.
//       The operand is taken on the rising edge where start=1 and in_ready=1.
//       start while in_ready=0 is ignored, not queued.
//     - Output side: out_valid rises with bcd/overflow(/sign) and holds them
//       stable until the rising edge where out_valid=1 and out_ready=1.
//
//   Parameters: WIDTH  - binary operand width
//               DIGITS - number of BCD digits on bcd
//
//   Optional: BIN_BCD_SIGNED_EN adds the sign signal.
//
//   Modports:   master - producer/consumer side (drives start, data_in, out_ready)
//               slave  - converter side (drives in_ready, out_valid, bcd,
//                        overflow, sign)
// -----------------------------------------------------------------------------
interface binary_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      data_in;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIGITS*4-1:0]   bcd;
  logic                  overflow;
`ifdef BIN_BCD_SIGNED_EN
  logic                  sign;
`endif

  modport master (
    output start, data_in, out_ready,
    input  in_ready, out_valid, bcd, overflow
`ifdef BIN_BCD_SIGNED_EN
    , input sign
`endif
  );

  modport slave (
    input  start, data_in, out_ready,
    output in_ready, out_valid, bcd, overflow
`ifdef BIN_BCD_SIGNED_EN
    , output sign
`endif
  );
endinterface

// File: rtl/binary_bcd_seq.sv
// -----------------------------------------------------------------------------
// binary_bcd_seq
//   Sequential binary-to-BCD converter (iterative double-dabble).
//   It converts one bit per clock. Each step first corrects every BCD digit
//   that is >= 5 by adding 3, then shifts {digits, binary} left by one.
//   A WIDTH-bit operand takes WIDTH SHIFT steps. The result then waits in
//   DONE until the consumer takes it.
//
// Parameters:
//   WIDTH  - binary operand width (>= 4)
//   DIGITS - number of BCD output digits (>= 1)
//
// Optional feature macro:
//   BIN_BCD_SIGNED_EN - treats data_in as two's complement and converts its
//                       magnitude. The sign output reports the operand sign.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - binary_bcd_seq_if.slave. It carries:
//                  start, data_in, in_ready          (input side)
//                  out_valid, out_ready, bcd,
//                  overflow, sign                    (output side)
//   state_dbg  - current FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//
// All outputs come straight from flops. start and out_ready only steer the
// next-state logic and never reach an output combinationally.
// -----------------------------------------------------------------------------
module binary_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  binary_bcd_seq_if.slave    bus,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  // Working registers
  logic [WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0] dig_sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  // Registered outputs
  logic [BCD_W-1:0] bcd_q;
  logic             overflow_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Per-step combinational datapath
  logic [BCD_W-1:0] dig_adj;
  logic [BCD_W-1:0] dig_next;
  logic [WIDTH-1:0] bin_next;
  logic             carry;
  logic [WIDTH-1:0] load_val;
  logic             accept;
  logic             last_step;

`ifdef BIN_BCD_SIGNED_EN
  logic load_sign;
  logic sign_acc;
  logic sign_q;

  // The magnitude of the most negative value, 2^(WIDTH-1), still fits in
  // WIDTH unsigned bits. A plain two's-complement negate is therefore exact.
  assign load_sign = bus.data_in[WIDTH-1];
  assign load_val  = load_sign ? (~bus.data_in + WIDTH'(1)) : bus.data_in;
`else
  assign load_val  = bus.data_in;
`endif

  assign accept    = (state == IDLE) && bus.start;
  assign last_step = (state == SHIFT) && (cnt == CNT_W'(1));

  // Add-3 correction, then a one-bit left shift across digits and binary.
  // Corrected digits only ever hold 0..9, so the 4-bit sum peaks at 12 and
  // never wraps. Bit 3 of the top digit leaves the register as carry. A set
  // carry means the value has crossed 10^DIGITS, and the digits that remain
  // hold the value mod 10^DIGITS.
  always_comb begin
    dig_adj = dig_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sr[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_sr[4*i +: 4] + 4'd3;
      end
    end
    carry    = dig_adj[BCD_W-1];
    dig_next = {dig_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
    bin_next = {bin_sr[WIDTH-2:0], 1'b0};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start)          state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1))   state_next = DONE;
      DONE:    if (bus.out_ready)      state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr      <= '0;
      dig_sr      <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BIN_BCD_SIGNED_EN
      sign_acc    <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      // Handshake flags follow the next state, so they are registered and
      // agree with the FSM on every cycle.
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);

      if (accept) begin
        bin_sr   <= load_val;
        dig_sr   <= '0;
        cnt      <= CNT_W'(WIDTH);
        ovf_acc  <= 1'b0;
`ifdef BIN_BCD_SIGNED_EN
        sign_acc <= load_sign;
`endif
      end else if (state == SHIFT) begin
        bin_sr  <= bin_next;
        dig_sr  <= dig_next;
        cnt     <= cnt - CNT_W'(1);
        ovf_acc <= ovf_acc | carry;
        // The final step publishes the shifted digits directly. The result
        // is therefore ready on the same edge that cnt reaches zero.
        if (last_step) begin
          bcd_q      <= dig_next;
          overflow_q <= ovf_acc | carry;
`ifdef BIN_BCD_SIGNED_EN
          sign_q     <= sign_acc;
`endif
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.overflow  = overflow_q;
`ifdef BIN_BCD_SIGNED_EN
  assign bus.sign      = sign_q;
`endif
  assign state_dbg     = state;

endmodule
